// File: rtl/com_uart_pkg.sv
// rtl/com_uart_pkg.sv - shared baud encodes, FSM states and frame constants for the UART receive path
package com_uart_pkg;

    localparam int UART_DATA_W = 8;
    localparam int UART_OVS    = 16;

    localparam logic [1:0] BD4800_ENCODE  = 2'd0;
    localparam logic [1:0] BD9600_ENCODE  = 2'd1;
    localparam logic [1:0] BD19200_ENCODE = 2'd2;
    localparam logic [1:0] BD38400_ENCODE = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    // Each step down from 38400 doubles the oversample period.
    function automatic logic [1:0] bd_shift(input logic [1:0] sel);
        return BD38400_ENCODE - sel;
    endfunction

endpackage

// File: rtl/com_uart_rx_tick_gen.sv
// rtl/com_uart_rx_tick_gen.sv - 16x oversample tick divider and per-bit tick counter with mid-bit sample point
module com_uart_rx_tick_gen
    import com_uart_pkg::*;
#(
    parameter int OVS_DIV38400 = 203
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic [1:0] sel,
    output logic       tick,
    output logic       sample_pt
);

    localparam int DIV_W = $clog2(OVS_DIV38400 * 8 + 1);
    localparam int TCK_W = $clog2(UART_OVS);
    localparam logic [TCK_W-1:0] SAMPLE_TICK = TCK_W'(UART_OVS / 2 - 1);

    logic [DIV_W-1:0] period;
    logic [DIV_W-1:0] div_cnt_q;
    logic [DIV_W-1:0] div_cnt_d;
    logic [TCK_W-1:0] tick_cnt_q;
    logic [TCK_W-1:0] tick_cnt_d;

    assign period = DIV_W'(OVS_DIV38400) << bd_shift(sel);
    assign tick   = (div_cnt_q >= period - 1'b1);

    // The sample point is the tick that advances tick_cnt to 7, so the
    // receiver acts exactly 7 periods after the counters were cleared.
    assign sample_pt = tick && (tick_cnt_q == SAMPLE_TICK - 1'b1);

    always_comb begin
        div_cnt_d  = div_cnt_q + 1'b1;
        tick_cnt_d = tick_cnt_q;
        if (clear) begin
            div_cnt_d  = '0;
            tick_cnt_d = '0;
        end else if (tick) begin
            div_cnt_d  = '0;
            tick_cnt_d = tick_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q  <= '0;
            tick_cnt_q <= '0;
        end else begin
            div_cnt_q  <= div_cnt_d;
            tick_cnt_q <= tick_cnt_d;
        end
    end

endmodule

// File: rtl/com_uart_receiver_ctrl.sv
// rtl/com_uart_receiver_ctrl.sv - 16x oversampled UART frame receiver with valid/ready byte output; COM_UART_RX_PARITY_EN adds a parity bit
module com_uart_receiver_ctrl
    import com_uart_pkg::*;
#(
    parameter int OVS_DIV38400 = 203,
    parameter int PARITY_ODD   = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             baudrate_sel,
    input  logic                   rx_port,
    output logic [UART_DATA_W-1:0] rx_data,
    output logic                   rx_valid,
    input  logic                   rx_ready,
    output logic                   rx_frame_err,
    output logic                   rx_parity_err,
    output logic                   rx_overrun,
    output logic                   stop_cond,
    output logic                   rx_busy
);

    localparam int BC_W = $clog2(UART_DATA_W);
    localparam logic [BC_W-1:0] LAST_BIT = BC_W'(UART_DATA_W - 1);

    logic                   rx_meta_q;
    logic                   rx_s_q;
    logic                   rx_prev_q;
    logic                   fall_edge;

    rx_state_e              state_q;
    logic [1:0]             sel_q;
    logic [UART_DATA_W-1:0] shreg_q;
    logic [BC_W-1:0]        bit_cnt_q;
    logic                   frame_err_st_q;
    logic                   busy_q;
    logic                   stop_cond_q;

    logic [UART_DATA_W-1:0] data_q;
    logic                   valid_q;
    logic                   frame_err_q;
    logic                   overrun_q;

    logic                   tick_unused;
    logic                   sample_pt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx_port;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    assign fall_edge = rx_prev_q && !rx_s_q;

    com_uart_rx_tick_gen #(
        .OVS_DIV38400(OVS_DIV38400)
    ) u_tick_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (state_q == IDLE),
        .sel      (sel_q),
        .tick     (tick_unused),
        .sample_pt(sample_pt)
    );

`ifdef COM_UART_RX_PARITY_EN
    localparam logic PAR_ODD = (PARITY_ODD != 0);
    logic parity_err_st_q;
    logic parity_err_q;
`else
    logic unused_parity_odd;
    assign unused_parity_odd = (PARITY_ODD != 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            sel_q           <= BD38400_ENCODE;
            shreg_q         <= '0;
            bit_cnt_q       <= '0;
            frame_err_st_q  <= 1'b0;
            busy_q          <= 1'b0;
            stop_cond_q     <= 1'b0;
`ifdef COM_UART_RX_PARITY_EN
            parity_err_st_q <= 1'b0;
`endif
        end else begin
            stop_cond_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (fall_edge) begin
                        sel_q     <= baudrate_sel;
                        bit_cnt_q <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= START;
                    end
                end
                START: begin
                    if (sample_pt) begin
                        if (!rx_s_q) begin
                            state_q <= DATA;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (sample_pt) begin
                        shreg_q   <= {rx_s_q, shreg_q[UART_DATA_W-1:1]};
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == LAST_BIT) begin
`ifdef COM_UART_RX_PARITY_EN
                            state_q <= PARITY;
`else
                            state_q <= STOP;
`endif
                        end
                    end
                end
`ifdef COM_UART_RX_PARITY_EN
                PARITY: begin
                    if (sample_pt) begin
                        parity_err_st_q <= (^shreg_q) ^ rx_s_q ^ PAR_ODD;
                        state_q         <= STOP;
                    end
                end
`endif
                STOP: begin
                    // The cycle after the stop sample hands the byte to the
                    // output register; the rest of the stop bit is spent in IDLE.
                    if (stop_cond_q) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (sample_pt) begin
                        stop_cond_q    <= 1'b1;
                        frame_err_st_q <= !rx_s_q;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q       <= '0;
            valid_q      <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef COM_UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            overrun_q <= 1'b0;
            if (stop_cond_q) begin
                if (!valid_q || rx_ready) begin
                    data_q       <= shreg_q;
                    frame_err_q  <= frame_err_st_q;
                    valid_q      <= 1'b1;
`ifdef COM_UART_RX_PARITY_EN
                    parity_err_q <= parity_err_st_q;
`endif
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (valid_q && rx_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign rx_data      = data_q;
    assign rx_valid     = valid_q;
    assign rx_frame_err = frame_err_q;
    assign rx_overrun   = overrun_q;
    assign stop_cond    = stop_cond_q;
    assign rx_busy      = busy_q;
`ifdef COM_UART_RX_PARITY_EN
    assign rx_parity_err = parity_err_q;
`else
    assign rx_parity_err = 1'b0;
`endif

endmodule
